// File: rtl/trace_pkg.sv
// Shared types for the bus trace buffer: entry layout, capture state, bus widths.
// The entry gains a timestamp field when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;
`ifdef TRACE_TIMESTAMP_EN
   localparam int TS_W = 16;
`endif

   typedef enum logic [1:0] {ARMED, POST, FROZEN} trace_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              rw;
      logic              uds;
      logic              lds;
`ifdef TRACE_TIMESTAMP_EN
      logic [TS_W-1:0]   ts;
`endif
   } trace_entry_t;
endpackage

// File: rtl/bus_trace_buffer_if.sv
// CPU bus observation and trace read-back signals; master drives the bus side, slave is the trace buffer.
interface bus_trace_buffer_if #(parameter int DEPTH_LOG2 = 4);
   import trace_pkg::*;

   logic                  videoBusControl;
   logic                  _dtackIn;
   logic [ADDR_W-1:0]     cpuAddr;
   logic                  _cpuRW;
   logic                  _cpuUDS;
   logic                  _cpuLDS;
   logic [DATA_W-1:0]     dataControllerDataOut;
   logic [DATA_W-1:0]     cpuDataOut;
   logic                  freeze;
   logic                  clear;
   logic                  trigEnable;
   logic [ADDR_W-1:0]     trigAddr;
   logic [DEPTH_LOG2-1:0] rdIndex;

   logic [ADDR_W-1:0]     rdAddr;
   logic [DATA_W-1:0]     rdData;
   logic                  rdRW;
   logic                  rdUDS;
   logic                  rdLDS;
   logic [15:0]           rdTimestamp;
   logic                  rdValid;
   logic [DEPTH_LOG2:0]   entryCount;
   logic                  triggered;
   logic                  frozen;

   modport master (
      output videoBusControl, _dtackIn, cpuAddr, _cpuRW, _cpuUDS, _cpuLDS,
             dataControllerDataOut, cpuDataOut, freeze, clear, trigEnable, trigAddr, rdIndex,
      input  rdAddr, rdData, rdRW, rdUDS, rdLDS, rdTimestamp, rdValid, entryCount, triggered, frozen
   );

   modport slave (
      input  videoBusControl, _dtackIn, cpuAddr, _cpuRW, _cpuUDS, _cpuLDS,
             dataControllerDataOut, cpuDataOut, freeze, clear, trigEnable, trigAddr, rdIndex,
      output rdAddr, rdData, rdRW, rdUDS, rdLDS, rdTimestamp, rdValid, entryCount, triggered, frozen
   );
endinterface

// File: rtl/trace_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1 clock, read-before-write).
// No flow control; the read port returns the pre-write contents on a same-address same-edge access.
module trace_ram #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [WIDTH-1:0]      rdata_o
);
   logic [WIDTH-1:0] mem [1 << DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      rdata_o <= mem[raddr_i];
   end
endmodule

// File: rtl/bus_trace_buffer.sv
// Circular history of completed 68000 bus cycles with address trigger and post-trigger freeze; reads have 1 clock latency.
// Captures cannot be stalled: cycles seen while frozen, cleared or video-owned are dropped. TRACE_TIMESTAMP_EN adds a 16-bit stamp.
module bus_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH_LOG2   = 4,
   parameter int POST_TRIGGER = 8
) (
   input logic                clk8,
   input logic                _reset,
   bus_trace_buffer_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PC_W  = $clog2(POST_TRIGGER + 2);
   localparam int EW    = $bits(trace_entry_t);

   logic                  cycle_done, capture_ev, wr_en, trig_hit;
   logic [DEPTH_LOG2-1:0] head_q, raddr;
   logic [DEPTH_LOG2:0]   count_q;
   logic [PC_W-1:0]       post_q;
   logic                  triggered_q, rearm_q, rd_valid_q;
   trace_state_t          state_q;
   trace_entry_t          wr_entry, rd_entry;
   logic [EW-1:0]         rd_raw;

   assign cycle_done = !bus.videoBusControl && !bus._dtackIn && (!bus._cpuUDS || !bus._cpuLDS);
   assign capture_ev = cycle_done && rearm_q;
   assign wr_en      = capture_ev && !bus.clear && !bus.freeze && (state_q != FROZEN);
   assign trig_hit   = bus.trigEnable && (bus.cpuAddr == bus.trigAddr);
   assign raddr      = head_q - DEPTH_LOG2'(1) - bus.rdIndex;

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk8 or negedge _reset) begin
      if (!_reset) ts_q <= '0;
      else         ts_q <= ts_q + TS_W'(1);
   end
`endif

   always_comb begin
      wr_entry      = '0;
      wr_entry.addr = bus.cpuAddr;
      wr_entry.data = bus._cpuRW ? bus.dataControllerDataOut : bus.cpuDataOut;
      wr_entry.rw   = bus._cpuRW;
      wr_entry.uds  = bus._cpuUDS;
      wr_entry.lds  = bus._cpuLDS;
`ifdef TRACE_TIMESTAMP_EN
      wr_entry.ts   = ts_q;
`endif
   end

   // The re-arm flag is consumed by any completed cycle, even one that is then dropped.
   always_ff @(posedge clk8 or negedge _reset) begin
      if (!_reset) begin
         head_q      <= '0;
         count_q     <= '0;
         post_q      <= '0;
         triggered_q <= 1'b0;
         rearm_q     <= 1'b1;
         rd_valid_q  <= 1'b0;
         state_q     <= ARMED;
      end else begin
         rd_valid_q <= ({1'b0, bus.rdIndex} < count_q);
         if (bus._cpuUDS && bus._cpuLDS) rearm_q <= 1'b1;
         else if (capture_ev)            rearm_q <= 1'b0;

         if (bus.clear) begin
            head_q      <= '0;
            count_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            state_q     <= ARMED;
         end else if (wr_en) begin
            head_q <= head_q + DEPTH_LOG2'(1);
            if (count_q != (DEPTH_LOG2+1)'(DEPTH)) count_q <= count_q + (DEPTH_LOG2+1)'(1);
            case (state_q)
               ARMED: if (trig_hit) begin
                  triggered_q <= 1'b1;
                  post_q      <= PC_W'(POST_TRIGGER);
                  state_q     <= (POST_TRIGGER == 0) ? FROZEN : POST;
               end
               POST: begin
                  post_q <= post_q - PC_W'(1);
                  if (post_q == PC_W'(1)) state_q <= FROZEN;
               end
               default: ;
            endcase
         end
      end
   end

   trace_ram #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(EW)) u_ram (
      .clk     (clk8),
      .we_i    (wr_en),
      .waddr_i (head_q),
      .wdata_i (wr_entry),
      .raddr_i (raddr),
      .rdata_o (rd_raw)
   );

   assign rd_entry       = trace_entry_t'(rd_raw);
   assign bus.rdValid    = rd_valid_q;
   assign bus.rdAddr     = rd_valid_q ? rd_entry.addr : '0;
   assign bus.rdData     = rd_valid_q ? rd_entry.data : '0;
   assign bus.rdRW       = rd_valid_q && rd_entry.rw;
   assign bus.rdUDS      = rd_valid_q && rd_entry.uds;
   assign bus.rdLDS      = rd_valid_q && rd_entry.lds;
`ifdef TRACE_TIMESTAMP_EN
   assign bus.rdTimestamp = rd_valid_q ? rd_entry.ts : '0;
`else
   assign bus.rdTimestamp = '0;
`endif
   assign bus.entryCount = count_q;
   assign bus.triggered  = triggered_q;
   assign bus.frozen     = (state_q == FROZEN);
endmodule

// File: tb/tb_bus_trace_buffer.sv
// Scoreboard bench for bus_trace_buffer: a queue-based history model predicts every read-back.
module tb_bus_trace_buffer;
   localparam int DL2   = 4;
   localparam int DEPTH = 16;
   localparam int POST  = 8;

   logic clk8 = 1'b0;
   logic _reset;
   always #5 clk8 = ~clk8;

   bus_trace_buffer_if #(.DEPTH_LOG2(DL2)) bus ();

   bus_trace_buffer #(.DEPTH_LOG2(DL2), .POST_TRIGGER(POST)) dut (
      .clk8   (clk8),
      ._reset (_reset),
      .bus    (bus)
   );

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] data;
      logic        rw;
      logic        uds;
      logic        lds;
   } ent_t;

   typedef struct {
      string       tag;
      bit          valid;
      logic [23:0] addr;
      logic [15:0] data;
      bit          rw, uds, lds;
      int          cnt;
      bit          trig, frz;
   } exp_t;

   ent_t hist[$];   // newest entry first
   bit   m_trig, m_frozen;
   int   m_post;
   exp_t exp_q[$];
   bit   rd_req = 1'b0;
   int   checks = 0;
   int   errors = 0;

   function automatic void m_clear();
      hist.delete();
      m_trig = 1'b0;
      m_frozen = 1'b0;
      m_post = 0;
   endfunction

   function automatic void m_capture(input ent_t e);
      if (m_frozen) return;
      hist.push_front(e);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      if (!m_trig) begin
         if (bus.trigEnable && e.addr == bus.trigAddr) begin
            m_trig = 1'b1;
            m_post = POST;
            if (m_post == 0) m_frozen = 1'b1;
         end
      end else begin
         m_post--;
         if (m_post == 0) m_frozen = 1'b1;
      end
   endfunction

   function automatic exp_t mk_read(input int idx, input string tag);
      exp_t x;
      x.tag   = tag;
      x.valid = idx < hist.size();
      x.addr  = x.valid ? hist[idx].addr : 24'h0;
      x.data  = x.valid ? hist[idx].data : 16'h0;
      x.rw    = x.valid ? hist[idx].rw   : 1'b0;
      x.uds   = x.valid ? hist[idx].uds  : 1'b0;
      x.lds   = x.valid ? hist[idx].lds  : 1'b0;
      x.cnt   = hist.size();
      x.trig  = m_trig;
      x.frz   = m_frozen;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a read request sampled at a posedge is checked at the following negedge.
   initial begin : monitor
      exp_t e;
      bit pend;
      forever begin
         @(posedge clk8);
         pend = rd_req;
         if (pend) begin
            @(negedge clk8);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_underflow: got read with no expectation");
            end else begin
               e = exp_q.pop_front();
               chk({e.tag, " rdValid"},    32'(bus.rdValid),    32'(e.valid));
               chk({e.tag, " rdAddr"},     32'(bus.rdAddr),     32'(e.addr));
               chk({e.tag, " rdData"},     32'(bus.rdData),     32'(e.data));
               chk({e.tag, " rdRW"},       32'(bus.rdRW),       32'(e.rw));
               chk({e.tag, " rdUDS"},      32'(bus.rdUDS),      32'(e.uds));
               chk({e.tag, " rdLDS"},      32'(bus.rdLDS),      32'(e.lds));
               chk({e.tag, " entryCount"}, 32'(bus.entryCount), 32'(e.cnt));
               chk({e.tag, " triggered"},  32'(bus.triggered),  32'(e.trig));
               chk({e.tag, " frozen"},     32'(bus.frozen),     32'(e.frz));
`ifndef TRACE_TIMESTAMP_EN
               chk({e.tag, " rdTimestamp"}, 32'(bus.rdTimestamp), 32'h0);
`endif
            end
         end
      end
   end

   task automatic read_idx(input int idx, input string tag);
      @(posedge clk8); #1;
      bus.rdIndex = DL2'(idx);
      exp_q.push_back(mk_read(idx, tag));
      rd_req = 1'b1;
      @(posedge clk8); #1;
      rd_req = 1'b0;
   endtask

   task automatic pulse_clear();
      @(posedge clk8); #1;
      bus.clear = 1'b1;
      m_clear();
      @(posedge clk8); #1;
      bus.clear = 1'b0;
   endtask

   // One bus cycle: strobes+DTACK held for 'hold' clocks, then one idle clock with strobes high.
   task automatic bus_cycle(input logic [23:0] addr, input bit rw, input logic [15:0] data,
                            input bit [1:0] strb, input int hold, input bit vid, input bit frz,
                            input bit clr, input bit rd_same, input int rd_idx, input string tag);
      ent_t e;
      exp_t x;
      @(posedge clk8); #1;
      bus.cpuAddr = addr;
      bus._cpuRW = rw;
      bus.dataControllerDataOut = rw ? data : 16'($urandom);
      bus.cpuDataOut = rw ? 16'($urandom) : data;
      {bus._cpuUDS, bus._cpuLDS} = strb;
      bus._dtackIn = 1'b0;
      bus.videoBusControl = vid;
      bus.freeze = frz;
      bus.clear = clr;
      if (rd_same) begin
         bus.rdIndex = DL2'(rd_idx);
         x = mk_read(rd_idx, tag);
      end
      e = '{addr, data, rw, strb[1], strb[0]};
      if (clr) m_clear();
      else if (!vid && !frz) m_capture(e);
      if (rd_same) begin
         x.cnt = hist.size();
         x.trig = m_trig;
         x.frz = m_frozen;
         exp_q.push_back(x);
         rd_req = 1'b1;
      end
      repeat (hold) begin
         @(posedge clk8); #1;
         bus.clear = 1'b0;
         rd_req = 1'b0;
      end
      bus._cpuUDS = 1'b1;
      bus._cpuLDS = 1'b1;
      bus._dtackIn = 1'b1;
      @(posedge clk8); #1;
      bus.videoBusControl = 1'b0;
      bus.freeze = 1'b0;
   endtask

   initial begin : stim
      bit [1:0] strb;
      _reset = 1'b0;
      bus.videoBusControl = 1'b0;
      bus._dtackIn = 1'b1;
      bus.cpuAddr = '0;
      bus._cpuRW = 1'b1;
      bus._cpuUDS = 1'b1;
      bus._cpuLDS = 1'b1;
      bus.dataControllerDataOut = '0;
      bus.cpuDataOut = '0;
      bus.freeze = 1'b0;
      bus.clear = 1'b0;
      bus.trigEnable = 1'b0;
      bus.trigAddr = '0;
      bus.rdIndex = '0;
      m_clear();
      repeat (3) @(posedge clk8);
      #1 _reset = 1'b1;

      read_idx(0, "reset_idx0");
      read_idx(5, "reset_idx5");

      // Three reads, the last with a same-edge read of index 0
      bus_cycle(24'h000400, 1, 16'h1111, 2'b00, 1, 0, 0, 0, 0, 0, "t_read1");
      bus_cycle(24'h000402, 1, 16'h2222, 2'b00, 1, 0, 0, 0, 0, 0, "t_read2");
      bus_cycle(24'h000404, 1, 16'h3333, 2'b00, 1, 0, 0, 0, 1, 0, "same_edge_idx0");
      read_idx(0, "three_idx0");
      read_idx(2, "three_idx2");
      read_idx(3, "three_idx3");

      // Long-held write cycle yields exactly one entry
      pulse_clear();
      bus_cycle(24'h001000, 0, 16'hBEEF, 2'b00, 5, 0, 0, 0, 0, 0, "long");
      read_idx(0, "long_idx0");
      read_idx(1, "long_idx1");

      // Wrap-around
      pulse_clear();
      for (int i = 0; i < 20; i++)
         bus_cycle(24'(i * 2), 1, 16'($urandom), 2'b00, 1, 0, 0, 0, 0, 0, "wrap");
      read_idx(0, "wrap_idx0");
      read_idx(15, "wrap_idx15");
      read_idx(7, "wrap_idx7");

      // Trigger with post window
      pulse_clear();
      bus.trigEnable = 1'b1;
      bus.trigAddr = 24'h00F000;
      for (int i = 0; i < 17; i++)
         bus_cycle((i == 4) ? 24'h00F000 : 24'h000200 + 24'(2 * i), 1, 16'($urandom),
                   2'b00, 1, 0, 0, 0, 0, 0, "trig");
      read_idx(8, "trig_idx8");
      read_idx(0, "trig_idx0");
      read_idx(12, "trig_idx12");
      read_idx(13, "trig_idx13");

      // Freeze and video-owned cycles are dropped
      pulse_clear();
      bus.trigEnable = 1'b0;
      bus_cycle(24'h000500, 0, 16'hA5A5, 2'b01, 1, 0, 0, 0, 0, 0, "pre");
      bus_cycle(24'h000502, 1, 16'h5A5A, 2'b10, 2, 0, 0, 0, 0, 0, "pre");
      for (int i = 0; i < 3; i++)
         bus_cycle(24'h000600 + 24'(i), 1, 16'($urandom), 2'b00, 2, 0, 1, 0, 0, 0, "frz");
      for (int i = 0; i < 2; i++)
         bus_cycle(24'h000700 + 24'(i), 1, 16'($urandom), 2'b00, 2, 1, 0, 0, 0, 0, "vid");
      read_idx(0, "drop_idx0");
      read_idx(1, "drop_idx1");
      read_idx(2, "drop_idx2");
      bus.trigEnable = 1'b1;
      bus.trigAddr = 24'h003000;
      bus_cycle(24'h003000, 1, 16'h0BAD, 2'b00, 1, 0, 0, 0, 0, 0, "retrig");
      read_idx(0, "retrig_idx0");
      bus_cycle(24'h003002, 1, 16'h0C0D, 2'b00, 1, 0, 0, 1, 1, 0, "clear_cap");
      read_idx(0, "after_clear");
      bus.trigEnable = 1'b0;

      // Randomized traffic
      bus.trigAddr = 24'h000010;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 99) < 65) begin
            bus.trigEnable = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
               0:       strb = 2'b00;
               1:       strb = 2'b01;
               default: strb = 2'b10;
            endcase
            bus_cycle(24'($urandom_range(0, 15) * 2), 1'($urandom_range(0, 1)), 16'($urandom),
                      strb, $urandom_range(1, 3), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
                      ($urandom_range(0, 6) == 0), $urandom_range(0, 15), "rand_cyc");
         end else begin
            read_idx($urandom_range(0, 15), "rand_rd");
         end
      end

      // Reset asserted in the middle of a bus cycle
      bus.trigEnable = 1'b0;
      @(posedge clk8); #1;
      bus.cpuAddr = 24'h123456;
      bus._cpuRW = 1'b1;
      bus.dataControllerDataOut = 16'h5555;
      bus._cpuUDS = 1'b0;
      bus._cpuLDS = 1'b0;
      bus._dtackIn = 1'b0;
      @(posedge clk8); #3;
      _reset = 1'b0;
      m_clear();
      @(posedge clk8); #1;
      bus._cpuUDS = 1'b1;
      bus._cpuLDS = 1'b1;
      bus._dtackIn = 1'b1;
      @(posedge clk8); #1;
      _reset = 1'b1;
      read_idx(0, "post_reset_idx0");
      bus_cycle(24'h00ABCD, 0, 16'hCAFE, 2'b01, 2, 0, 0, 0, 0, 0, "post_reset_cyc");
      read_idx(0, "post_reset_first");
      read_idx(1, "post_reset_idx1");

      repeat (3) @(posedge clk8);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
